// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream serialiser: controller state encoding
// and counter sizing.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Down-counter must hold WIDTH+EXTRA_BITS without wrapping.
    function automatic int cnt_width(input int width, input int extra);
        return $clog2(width + extra + 1);
    endfunction

endpackage

// File: rtl/piso_lane.sv
// One serial lane: loadable shift register with selectable bit order and a registered output bit.
// Latency: bit appears the cycle after adv_i; idle level is driven whenever adv_i is low.
module piso_lane
    import piso_pkg::*;
#(
    parameter int WIDTH      = 42,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             dout_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] src;
    logic             dout_q;
    logic             dout_d;

    // A load and an advance on the same edge emit bit 0 straight from din_i,
    // which is what gives zero-gap framing when there is no lead-in.
    always_comb begin
        src    = load_i ? din_i : sr_q;
        sr_d   = sr_q;
        dout_d = IDLE_LEVEL;
        if (adv_i) begin
            dout_d = LSB_FIRST ? src[0] : src[WIDTH-1];
            sr_d   = LSB_FIRST ? (src >> 1) : (src << 1);
        end else if (load_i) begin
            sr_d = din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            dout_q <= IDLE_LEVEL;
        end else begin
            sr_q   <= sr_d;
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/piso_stream.sv
// Multi-lane parallel-in/serial-out serialiser with valid/ready load and per-frame status.
// Latency: EXTRA_BITS lead-in cycles after accept, then WIDTH data cycles; ready again on the last bit.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH      = 42,
    parameter int EXTRA_BITS = 9,
    parameter int LANES      = 1,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic [LANES-1:0]       data_out,
    output logic                   frame,
    output logic                   last,
    output logic                   busy
);

    localparam int            CW       = cnt_width(WIDTH, EXTRA_BITS);
    localparam logic [CW-1:0] TOTAL    = CW'(WIDTH + EXTRA_BITS);
    localparam logic [CW-1:0] DATA_LEN = CW'(WIDTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_dec;
    logic          frame_q;
    logic          last_q;
    logic          busy_q;
    logic          accept;
    logic          adv;

    assign in_ready = !busy_q || last_q;
    assign accept   = in_valid && in_ready;
    assign cnt_dec  = cnt_q - ONE;

    // cnt_q counts the busy cycles still to go, including the current one;
    // the data phase is the final WIDTH of them.
    always_comb begin
        adv = 1'b0;
        if (accept) begin
            adv = (EXTRA_BITS == 0);
        end else if (state_q == ST_PRE) begin
            adv = (cnt_dec == DATA_LEN);
        end else if (state_q == ST_SHIFT) begin
            adv = (cnt_q != ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (accept) begin
            cnt_q  <= TOTAL;
            busy_q <= 1'b1;
            if (EXTRA_BITS > 0) begin
                state_q <= ST_PRE;
                frame_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                state_q <= ST_SHIFT;
                frame_q <= 1'b1;
                last_q  <= (WIDTH == 1);
            end
        end else begin
            case (state_q)
                ST_PRE: begin
                    cnt_q <= cnt_dec;
                    if (cnt_dec == DATA_LEN) begin
                        state_q <= ST_SHIFT;
                        frame_q <= 1'b1;
                        last_q  <= (WIDTH == 1);
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == ONE) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        frame_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_dec;
                        last_q <= (cnt_q == TWO);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        piso_lane #(
            .WIDTH      (WIDTH),
            .LSB_FIRST  (LSB_FIRST),
            .IDLE_LEVEL (IDLE_LEVEL)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (accept),
            .adv_i  (adv),
            .din_i  (data_in[k*WIDTH +: WIDTH]),
            .dout_o (data_out[k])
        );
    end

    assign frame = frame_q;
    assign last  = last_q;
    assign busy  = busy_q;

endmodule
